// File: rtl/nn_pkg.sv
// Shared constants and sequencer state encoding for the two-layer neural datapath.
package nn_pkg;

  localparam int NUM_IN     = 62;
  localparam int NUM_HIDDEN = 30;
  localparam int NUM_OUT    = 10;
  localparam int DATA_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1_ISSUE,
    S_L1_WAIT,
    S_L1_WB,
    S_L2_ISSUE,
    S_L2_WAIT,
    S_L2_WB,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/nn_layer_sequencer_wait_timer.sv
// Clearable counter that saturates at TIMEOUT; expired_o is high while the count sits at the limit.
module wait_timer #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/nn_layer_sequencer.sv
// Steps the shared neuron engine through every hidden neuron, then every output neuron,
// and steers the input mux and register-file writes for one inference.
module nn_layer_sequencer #(
  parameter int NUM_HIDDEN = nn_pkg::NUM_HIDDEN,
  parameter int NUM_OUT    = nn_pkg::NUM_OUT,
  parameter int TIMEOUT    = 1023,
  parameter int IDX_W      = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   input_sel,
  output logic                   reg_sel,
  output logic                   neu_start,
  input  logic                   neu_done,
  output logic [IDX_W-1:0]       neuron_idx,
  output logic                   hid_we,
  output logic                   out_we,
  output logic [IDX_W-1:0]       wr_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output nn_pkg::seq_state_t     state_dbg
);

  import nn_pkg::*;

  localparam logic [IDX_W-1:0] HID_LAST = IDX_W'(NUM_HIDDEN - 1);
  localparam logic [IDX_W-1:0] OUT_LAST = IDX_W'(NUM_OUT - 1);

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             tmr_clr, tmr_en, tmr_expired;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // Handshake: a vector is taken on a cycle where in_valid and in_ready are both high;
  // in_ready is only high in IDLE, so in_valid while busy is ignored and never queued.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_L1_ISSUE;
          idx_d   = '0;
        end
      end
      S_L1_ISSUE: state_d = S_L1_WAIT;
      S_L1_WAIT: begin
        if (neu_done) begin
          state_d = S_L1_WB;
        end else if (tmr_expired) begin
          state_d = S_IDLE;
          idx_d   = '0;
          err_d   = 1'b1;
        end
      end
      S_L1_WB: begin
        if (idx_q == HID_LAST) begin
          state_d = S_L2_ISSUE;
          idx_d   = '0;
        end else begin
          state_d = S_L1_ISSUE;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_L2_ISSUE: state_d = S_L2_WAIT;
      S_L2_WAIT: begin
        if (neu_done) begin
          state_d = S_L2_WB;
        end else if (tmr_expired) begin
          state_d = S_IDLE;
          idx_d   = '0;
          err_d   = 1'b1;
        end
      end
      S_L2_WB: begin
        if (idx_q == OUT_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_L2_ISSUE;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // A done in the same cycle the timer expires still counts, so the timer only runs without it.
  assign tmr_clr = (state_q == S_L1_ISSUE) || (state_q == S_L2_ISSUE);
  assign tmr_en  = ((state_q == S_L1_WAIT) || (state_q == S_L2_WAIT)) && !neu_done;

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign input_sel  = (state_q == S_L1_ISSUE) || (state_q == S_L1_WAIT) || (state_q == S_L1_WB);
  assign reg_sel    = (state_q == S_L2_ISSUE) || (state_q == S_L2_WAIT) || (state_q == S_L2_WB);
  assign neu_start  = (state_q == S_L1_ISSUE) || (state_q == S_L2_ISSUE);
  assign hid_we     = (state_q == S_L1_WB);
  assign out_we     = (state_q == S_L2_WB);
  assign neuron_idx = idx_q;
  assign wr_addr    = idx_q;
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer: a cycle timeline planned from the latency rules is compared every cycle.
module tb_nn_layer_sequencer;

  localparam int NH   = 30;
  localparam int NO   = 10;
  localparam int TO   = 20;
  localparam int MAXC = 1024;

  typedef struct packed {
    logic       in_ready;
    logic       busy;
    logic       input_sel;
    logic       reg_sel;
    logic       neu_start;
    logic       hid_we;
    logic       out_we;
    logic       done;
    logic       err;
    logic [4:0] idx;
  } exp_t;

  logic clk, rst, in_valid, eng_done, stray_done, neu_done;
  logic in_ready, input_sel, reg_sel, neu_start, hid_we, out_we, busy, done, err;
  logic [4:0] neuron_idx, wr_addr;
  nn_pkg::seq_state_t state_dbg;

  assign neu_done = eng_done | stray_done;

  nn_layer_sequencer #(.NUM_HIDDEN(NH), .NUM_OUT(NO), .TIMEOUT(TO), .IDX_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .input_sel(input_sel), .reg_sel(reg_sel), .neu_start(neu_start), .neu_done(neu_done),
    .neuron_idx(neuron_idx), .hid_we(hid_we), .out_we(out_we), .wr_addr(wr_addr),
    .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // clock / reset
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_a [MAXC];
  int   lat_tab [NH+NO];
  int   eng_k;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, expv);
    end
  endtask

  function automatic exp_t idle_e();
    exp_t e;
    e = '0;
    e.in_ready = 1'b1;
    return e;
  endfunction

  function automatic void put(input int c, input exp_t e, input int stop_c);
    if (c < stop_c && c < MAXC) exp_a[c] = e;
  endfunction

  // Timeline model: neuron k occupies issue, L wait cycles, one writeback; latency 0 = engine silent.
  // Returns the done cycle, or -1 when the inference aborts.
  function automatic int plan(input int t_acc, input int stop_c);
    int   t;
    int   lat;
    exp_t e;
    t = t_acc + 1;
    for (int k = 0; k < NH + NO; k++) begin
      lat = lat_tab[k];
      e = '0;
      e.busy      = 1'b1;
      e.input_sel = (k < NH);
      e.reg_sel   = (k >= NH);
      e.idx       = (k < NH) ? 5'(k) : 5'(k - NH);
      e.neu_start = 1'b1;
      put(t, e, stop_c);
      e.neu_start = 1'b0;
      if (lat == 0) begin
        for (int w = 1; w <= TO + 1; w++) put(t + w, e, stop_c);
        e = idle_e();
        e.err = 1'b1;
        put(t + TO + 2, e, stop_c);
        return -1;
      end
      for (int w = 1; w <= lat; w++) put(t + w, e, stop_c);
      e.hid_we = (k < NH);
      e.out_we = (k >= NH);
      put(t + lat + 1, e, stop_c);
      t = t + lat + 2;
    end
    e = '0;
    e.busy = 1'b1;
    e.done = 1'b1;
    put(t, e, stop_c);
    return t;
  endfunction

  // compare process
  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 1 && cyc < MAXC) begin
      e = exp_a[cyc];
      check("in_ready", 32'(in_ready), 32'(e.in_ready));
      check("busy", 32'(busy), 32'(e.busy));
      check("input_sel", 32'(input_sel), 32'(e.input_sel));
      check("reg_sel", 32'(reg_sel), 32'(e.reg_sel));
      check("neu_start", 32'(neu_start), 32'(e.neu_start));
      check("hid_we", 32'(hid_we), 32'(e.hid_we));
      check("out_we", 32'(out_we), 32'(e.out_we));
      check("done", 32'(done), 32'(e.done));
      check("err", 32'(err), 32'(e.err));
      if (e.input_sel || e.reg_sel) check("neuron_idx", 32'(neuron_idx), 32'(e.idx));
      if (e.hid_we || e.out_we) check("wr_addr", 32'(wr_addr), 32'(e.idx));
    end
  end

  // event counters per scenario
  int hid_cnt, out_cnt, done_cnt, err_cnt, done_at, err_at;
  always @(negedge clk) begin
    if (hid_we) hid_cnt++;
    if (out_we) out_cnt++;
    if (done) begin done_cnt++; done_at = cyc; end
    if (err) begin err_cnt++; err_at = cyc; end
  end

  // engine model: answers each observed start after its table latency
  initial begin
    int lat;
    eng_done = 1'b0;
    forever begin
      @(negedge clk);
      if (neu_start === 1'b1) begin
        lat = (eng_k < NH + NO) ? lat_tab[eng_k] : 1;
        eng_k++;
        if (lat != 0) begin
          repeat (lat) @(posedge clk);
          #1 eng_done = 1'b1;
          @(posedge clk);
          #1 eng_done = 1'b0;
        end
      end
    end
  end

  // driver tasks
  task automatic at_cycle(input int n);
    if (cyc > n) begin
      n_bad++;
      $display("FAIL schedule: at cycle %0d, wanted %0d", cyc, n);
    end
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_counts();
    hid_cnt = 0; out_cnt = 0; done_cnt = 0; err_cnt = 0; done_at = -1; err_at = -1;
  endtask

  task automatic accept(input int t);
    at_cycle(t);
    clr_counts();
    eng_k    = 0;
    in_valid = 1'b1;
  endtask

  initial begin
    #(MAXC * 10 + 200);
    $display("FAIL watchdog: simulation did not reach its end by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int sum;
    rst = 1'b1; in_valid = 1'b0; stray_done = 1'b0; eng_k = 0;
    for (int c = 0; c < MAXC; c++) exp_a[c] = idle_e();
    clr_counts();
    at_cycle(2);
    rst = 1'b0;

    // idle window cycles 1..29 checked by the compare process; then full inference, L=1
    for (int k = 0; k < NH + NO; k++) lat_tab[k] = 1;
    d = plan(30, MAXC);
    check("plan_done_L1", 32'(d), 32'd151);
    accept(30);
    at_cycle(31); in_valid = 1'b0;
    at_cycle(160);
    check("done_at_L1", 32'(done_at), 32'd151);
    check("hid_cnt_L1", 32'(hid_cnt), 32'd30);
    check("out_cnt_L1", 32'(out_cnt), 32'd10);
    check("err_cnt_L1", 32'(err_cnt), 32'd0);

    // random latency 1..7 per neuron
    sum = 0;
    for (int k = 0; k < NH + NO; k++) begin
      lat_tab[k] = $urandom_range(1, 7);
      sum += lat_tab[k] + 2;
    end
    d = plan(170, MAXC);
    check("plan_done_rand", 32'(d), 32'(170 + 1 + sum));
    accept(170);
    at_cycle(171); in_valid = 1'b0;
    at_cycle(d + 5);
    check("done_at_rand", 32'(done_at), 32'(170 + 1 + sum));
    check("hid_cnt_rand", 32'(hid_cnt), 32'd30);
    check("out_cnt_rand", 32'(out_cnt), 32'd10);

    // engine silent on hidden neuron 12: issue at 597, err at 597+TO+2
    for (int k = 0; k < NH + NO; k++) lat_tab[k] = 1;
    lat_tab[12] = 0;
    d = plan(560, MAXC);
    check("plan_abort", 32'(d), 32'hFFFF_FFFF);
    accept(560);
    at_cycle(561); in_valid = 1'b0;
    at_cycle(640);
    check("err_at", 32'(err_at), 32'd619);
    check("err_cnt_to", 32'(err_cnt), 32'd1);
    check("done_cnt_to", 32'(done_cnt), 32'd0);
    check("hid_cnt_to", 32'(hid_cnt), 32'd12);
    check("out_cnt_to", 32'(out_cnt), 32'd0);

    // reset in L2_WAIT of output neuron 4 (issued at 787), stray done in IDLE afterwards
    for (int k = 0; k < NH + NO; k++) lat_tab[k] = 2;
    lat_tab[34] = 3;
    d = plan(650, 789);
    accept(650);
    at_cycle(651); in_valid = 1'b0;
    at_cycle(788); rst = 1'b1;
    at_cycle(789); rst = 1'b0;
    at_cycle(795); stray_done = 1'b1;
    at_cycle(796); stray_done = 1'b0;
    check("hid_cnt_rst", 32'(hid_cnt), 32'd30);
    check("out_cnt_rst", 32'(out_cnt), 32'd4);
    check("done_cnt_rst", 32'(done_cnt), 32'd0);
    check("err_cnt_rst", 32'(err_cnt), 32'd0);

    // restart; in_valid held high while busy, stray done in issue cycles of neurons 5 and 32
    for (int k = 0; k < NH + NO; k++) lat_tab[k] = 1;
    d = plan(800, MAXC);
    check("plan_done_hold", 32'(d), 32'd921);
    accept(800);
    at_cycle(816); stray_done = 1'b1;
    at_cycle(817); stray_done = 1'b0;
    at_cycle(897); stray_done = 1'b1;
    at_cycle(898); stray_done = 1'b0;
    at_cycle(921); in_valid = 1'b0;
    at_cycle(940);
    check("done_at_hold", 32'(done_at), 32'd921);
    check("done_cnt_hold", 32'(done_cnt), 32'd1);
    check("hid_cnt_hold", 32'(hid_cnt), 32'd30);
    check("out_cnt_hold", 32'(out_cnt), 32'd10);

    at_cycle(950);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
